scam_blk_ctrl: RTL

- Parametrised SCA block-cycle controller for the CFEB SCA write path.
- Generalised successor of the fixed 16-sample, 3-deep SCA controller. Block length and LCT history depth are parameters; the LCT match window is a runtime mask.
- Adds block resynchronisation and a per-block LCT count snapshot.
- Sits between the LCT delay pipe and the SCA block-address/write logic; drives the block-end, next-block-select and write-enable strobes.

---
 rtl/scam_blk_ctrl_if.sv | 39 +++
 rtl/scam_blk_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/scam_blk_ctrl_if.sv
// Signal bundle between the LCT delay pipe / SCA write logic (master) and scam_blk_ctrl (slave).
interface scam_blk_ctrl_if #(
    parameter int HIST  = 3,
    parameter int SW    = 4,
    parameter int CNT_W = 4
);
    logic             SYNC;
    logic             LCTDLY;
    logic [HIST-1:0]  MTCH_MASK;
    logic             DONE;
    logic             NOGTRG;
    logic             NODATA;
    logic             DLSCAFULL;
    logic             DSCAFULL;
    logic [SW-1:0]    STATE;
    logic             PREBLKEND;
    logic             NBSEL;
    logic             ENAREG;
    logic             SELA;
    logic             SELB;
    logic             SELC;
    logic             WRENA;
    logic             LCTYENA;
    logic             NOLCT;
    logic [CNT_W-1:0] LCT_CNT;
    logic             LCT_MULTI;

    modport master (
        output SYNC, LCTDLY, MTCH_MASK, DONE, NOGTRG, NODATA, DLSCAFULL, DSCAFULL,
        input  STATE, PREBLKEND, NBSEL, ENAREG, SELA, SELB, SELC, WRENA, LCTYENA, NOLCT,
               LCT_CNT, LCT_MULTI
    );

    modport slave (
        input  SYNC, LCTDLY, MTCH_MASK, DONE, NOGTRG, NODATA, DLSCAFULL, DSCAFULL,
        output STATE, PREBLKEND, NBSEL, ENAREG, SELA, SELB, SELC, WRENA, LCTYENA, NOLCT,
               LCT_CNT, LCT_MULTI
    );
endinterface

// File: rtl/scam_blk_ctrl.sv
// SCA block-cycle controller: sample counter per SCA block, per-block LCT history and count
// snapshot, and the write-path strobes decoded from the sample counter.
module scam_blk_ctrl #(
    parameter int TMR     = 0,
    parameter int BLK_LEN = 16,
    parameter int HIST    = 3,
    parameter int CNT_W   = 4
) (
    input  logic           CLK,
    input  logic           RST,
    scam_blk_ctrl_if.slave bus
);
    localparam int SW  = $clog2(BLK_LEN);
    localparam int NCP = (TMR != 0) ? 3 : 1;

    localparam logic [SW-1:0]    POS_PRE  = SW'(BLK_LEN - 3);
    localparam logic [SW-1:0]    POS_NB   = SW'(BLK_LEN - 2);
    localparam logic [SW-1:0]    POS_END  = SW'(BLK_LEN - 1);
    localparam logic [SW-1:0]    POS_SELA = SW'(5);
    localparam logic [SW-1:0]    POS_SELB = SW'(3);
    localparam logic [SW-1:0]    POS_SELC = SW'(2);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [SW-1:0]    state_q [NCP];
    logic [CNT_W-1:0] cnt_q   [NCP];
    logic [HIST-1:0]  hist_q  [NCP];

    logic [SW-1:0]    state_v, state_d;
    logic [CNT_W-1:0] cnt_v, cnt_d, cnt_snap;
    logic [HIST-1:0]  hist_v, hist_d;
    logic [CNT_W-1:0] lct_cnt_q;
    logic             lct_multi_q;

    logic pre_blk_end, nb_sel, ena_reg;
    logic sel_a, sel_b, sel_c;
    logic lct_save, llct, no_lct;

    // Each TMR copy reloads from the voted value, so a single upset is scrubbed on the next edge.
    generate
        if (TMR != 0) begin : g_tmr
            assign state_v = (state_q[0] & state_q[1]) | (state_q[0] & state_q[2]) |
                             (state_q[1] & state_q[2]);
            assign cnt_v   = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) |
                             (cnt_q[1] & cnt_q[2]);
            assign hist_v  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                             (hist_q[1] & hist_q[2]);
        end else begin : g_single
            assign state_v = state_q[0];
            assign cnt_v   = cnt_q[0];
            assign hist_v  = hist_q[0];
        end
    endgenerate

    always_comb begin
        pre_blk_end = (state_v == POS_PRE);
        nb_sel      = (state_v == POS_NB);
        ena_reg     = (state_v == POS_END);
        sel_a       = (state_v == POS_SELA);
        sel_b       = bus.NOGTRG & ~bus.DLSCAFULL & (state_v == POS_SELB);
        sel_c       = bus.DONE & ~bus.NODATA & (state_v == POS_SELC);
        llct        = |(hist_v & bus.MTCH_MASK);
        no_lct      = ~llct & ~bus.DSCAFULL & nb_sel;
        lct_save    = (cnt_v != '0) | bus.LCTDLY;
        // The snapshot folds in an LCT that lands exactly on the pre-block-end cycle.
        cnt_snap    = (cnt_v == CNT_MAX) ? CNT_MAX : cnt_v + CNT_W'(bus.LCTDLY);
    end

    always_comb begin
        state_d = (state_v == POS_END) ? '0 : state_v + SW'(1);
        cnt_d   = cnt_v;
        hist_d  = hist_v;
        if (bus.SYNC) begin
            state_d = '0;
        end
        if (bus.SYNC || pre_blk_end) begin
            cnt_d = '0;
        end else if (bus.LCTDLY && (cnt_v != CNT_MAX)) begin
            cnt_d = cnt_v + CNT_W'(1);
        end
        // Truncating the concatenation drops the oldest history bit.
        if (pre_blk_end) begin
            hist_d = HIST'({hist_v, lct_save});
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NCP; k++) begin
                state_q[k] <= '0;
                cnt_q[k]   <= '0;
                hist_q[k]  <= '0;
            end
            lct_cnt_q   <= '0;
            lct_multi_q <= 1'b0;
        end else begin
            for (int k = 0; k < NCP; k++) begin
                state_q[k] <= state_d;
                cnt_q[k]   <= cnt_d;
                hist_q[k]  <= hist_d;
            end
            if (pre_blk_end) begin
                lct_cnt_q   <= cnt_snap;
                lct_multi_q <= (cnt_snap > CNT_W'(1));
            end
        end
    end

    assign bus.STATE     = state_v;
    assign bus.PREBLKEND = pre_blk_end;
    assign bus.NBSEL     = nb_sel;
    assign bus.ENAREG    = ena_reg;
    assign bus.SELA      = sel_a;
    assign bus.SELB      = sel_b;
    assign bus.SELC      = sel_c;
    assign bus.LCTYENA   = llct & nb_sel;
    assign bus.NOLCT     = no_lct;
    assign bus.WRENA     = sel_a | sel_b | sel_c | no_lct;
    assign bus.LCT_CNT   = lct_cnt_q;
    assign bus.LCT_MULTI = lct_multi_q;
endmodule
